// File: rtl/macc_pkg.sv
// Shared widths, latency and the per-beat control bundle
// carried alongside operands down the macc pipeline.
package macc_pkg;

  localparam int MACC_A_W     = 25;
  localparam int MACC_B_W     = 18;
  localparam int MACC_P_W     = 48;
  localparam int MACC_LATENCY = 4;

  typedef struct packed {
    logic valid;
    logic carryin;
    logic acc_en;
  } macc_beat_t;

endpackage

// File: rtl/macc_if.sv
// Operand/result bundle between the macc requester and
// the macc_pipe responder.
interface macc_if
  import macc_pkg::*;
#(
  parameter int A_W = MACC_A_W,
  parameter int B_W = MACC_B_W,
  parameter int P_W = MACC_P_W
);

  logic           ce;
  logic           valid_in;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           carryin;
  logic           acc_en;
  logic [P_W-1:0] p;
  logic           valid_out;
  logic           ovf;

  modport master (
    output ce, valid_in, a, b,
    output carryin, acc_en,
    input  p, valid_out, ovf
  );

  modport slave (
    input  ce, valid_in, a, b,
    input  carryin, acc_en,
    output p, valid_out, ovf
  );

endinterface

// File: rtl/macc_mult_stage.sv
// S1 operand registers and S2 registered product, kept
// together so they map onto the DSP A/B/M registers.
module macc_mult_stage
  import macc_pkg::*;
#(
  parameter int A_W = MACC_A_W,
  parameter int B_W = MACC_B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  macc_beat_t       beat_in,
  output logic [A_W+B_W-1:0] m,
  output macc_beat_t       beat_out
);

  localparam int M_W = A_W + B_W;

  logic [A_W-1:0] a_r;
  logic [B_W-1:0] b_r;
  macc_beat_t     beat1;
  logic [M_W-1:0] prod;

  assign prod = M_W'(a_r) * M_W'(b_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      beat1    <= '0;
      m        <= '0;
      beat_out <= '0;
    end else if (ce) begin
      a_r      <= a;
      b_r      <= b;
      beat1    <= beat_in;
      m        <= prod;
      beat_out <= beat1;
    end
  end

endmodule

// File: rtl/macc_pipe.sv
// Four-stage unsigned multiply-accumulate, p = a*b + carryin.
// Define MACC_SATURATE_EN to clamp p on accumulate overflow.
module macc_pipe
  import macc_pkg::*;
#(
  parameter int A_W = MACC_A_W,
  parameter int B_W = MACC_B_W,
  parameter int P_W = MACC_P_W
) (
  input  logic clk,
  input  logic rst,
  macc_if.slave bus
);

  localparam int M_W = A_W + B_W;

  macc_beat_t     beat_in;
  macc_beat_t     beat2;
  logic [M_W-1:0] m;

  logic [P_W-1:0] s_r;
  logic           v3;
  logic           acc3;

  logic [P_W-1:0] p_r;
  logic           vout_r;
  logic           ovf_r;

  logic [P_W:0]   acc_sum;
  logic [P_W-1:0] acc_next;

  assign beat_in = '{
    valid:   bus.valid_in,
    carryin: bus.carryin,
    acc_en:  bus.acc_en
  };

  macc_mult_stage #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .ce       (bus.ce),
    .a        (bus.a),
    .b        (bus.b),
    .beat_in  (beat_in),
    .m        (m),
    .beat_out (beat2)
  );

  // One extra bit catches the carry out of the accumulate.
  assign acc_sum = {1'b0, p_r} + {1'b0, s_r};

`ifdef MACC_SATURATE_EN
  assign acc_next = acc_sum[P_W] ? '1 : acc_sum[P_W-1:0];
`else
  assign acc_next = acc_sum[P_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= '0;
      v3     <= 1'b0;
      acc3   <= 1'b0;
      p_r    <= '0;
      vout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (bus.ce) begin
      s_r    <= P_W'(m) + P_W'(beat2.carryin);
      v3     <= beat2.valid;
      acc3   <= beat2.acc_en;
      vout_r <= v3;
      if (v3) begin
        if (acc3) begin
          p_r <= acc_next;
          if (acc_sum[P_W]) ovf_r <= 1'b1;
        end else begin
          p_r <= s_r;
        end
      end
    end
  end

  assign bus.p         = p_r;
  assign bus.valid_out = vout_r;
  assign bus.ovf       = ovf_r;

endmodule
